imem_fetch: RTL and testbench



---
 rtl/imem_fetch.sv | 129 ++++++++++++
 tb/tb_imem_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction fetch: PC, 16:1 ROM word select, registered instruction with 1-cycle latency.
// Stall holds all fetch state, branch redirect costs one bubble, and a halt opcode freezes fetch until reset.
module imem_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] w0,
  input  logic [15:0] w1,
  input  logic [15:0] w2,
  input  logic [15:0] w3,
  input  logic [15:0] w4,
  input  logic [15:0] w5,
  input  logic [15:0] w6,
  input  logic [15:0] w7,
  input  logic [15:0] w8,
  input  logic [15:0] w9,
  input  logic [15:0] w10,
  input  logic [15:0] w11,
  input  logic [15:0] w12,
  input  logic [15:0] w13,
  input  logic [15:0] w14,
  input  logic [15:0] w15,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [3:0]  br_target,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [3:0]  instr_pc,
  output logic [3:0]  pc,
  output logic        halted,
  output logic [7:0]  fetch_cnt
);

  localparam logic [3:0]  HALT_OP  = 4'b1111;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [3:0]  instr_pc_q, instr_pc_d;
  logic [7:0]  fetch_cnt_q, fetch_cnt_d;

  logic [15:0] rom [16];
  logic [15:0] sel;

  assign rom[0]  = w0;
  assign rom[1]  = w1;
  assign rom[2]  = w2;
  assign rom[3]  = w3;
  assign rom[4]  = w4;
  assign rom[5]  = w5;
  assign rom[6]  = w6;
  assign rom[7]  = w7;
  assign rom[8]  = w8;
  assign rom[9]  = w9;
  assign rom[10] = w10;
  assign rom[11] = w11;
  assign rom[12] = w12;
  assign rom[13] = w13;
  assign rom[14] = w14;
  assign rom[15] = w15;
  assign sel     = rom[pc_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= 4'd0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= 4'd0;
      fetch_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    fetch_cnt_d   = fetch_cnt_q;
    case (state_q)
      S_RUN: begin
        // Redirect wins over stall; the squashed slot never looks at sel, so no halt detect.
        if (br_taken) begin
          pc_d          = br_target;
          instr_d       = NOP_WORD;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_d       = sel;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          fetch_cnt_d   = (fetch_cnt_q == 8'hFF) ? fetch_cnt_q : fetch_cnt_q + 8'd1;
          if (sel[15:12] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      S_HALT: begin
        // Halt word is issued once: valid drops on the first accepted cycle.
        if (!stall) begin
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    instr       = instr_q;
    instr_valid = instr_valid_q;
    instr_pc    = instr_pc_q;
    pc          = pc_q;
    halted      = (state_q == S_HALT);
    fetch_cnt   = fetch_cnt_q;
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed self-checking bench for imem_fetch.
module tb_imem_fetch;
  logic        clk;
  logic        rst;
  logic [15:0] w [16];
  logic        stall;
  logic        br_taken;
  logic [3:0]  br_target;
  logic [15:0] instr;
  logic        instr_valid;
  logic [3:0]  instr_pc;
  logic [3:0]  pc;
  logic        halted;
  logic [7:0]  fetch_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  imem_fetch dut (
    .clk(clk), .rst(rst),
    .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]),
    .w4(w[4]), .w5(w[5]), .w6(w[6]), .w7(w[7]),
    .w8(w[8]), .w9(w[9]), .w10(w[10]), .w11(w[11]),
    .w12(w[12]), .w13(w[13]), .w14(w[14]), .w15(w[15]),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .pc(pc), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_straight();
    for (int i = 0; i < 16; i++) w[i] = 16'h0000;
    w[1] = 16'h1400;
    w[2] = 16'h1304;
    w[3] = 16'h3C02;
    w[4] = 16'hF000;
  endtask

  logic [15:0] exp_sl [5];

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 4'd0;
    load_straight();
    exp_sl = '{16'h0000, 16'h1400, 16'h1304, 16'h3C02, 16'hF000};
    tick();
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_ipc",   16'(instr_pc), 16'd0);
    chk("rst_pc",    16'(pc), 16'd0);
    chk("rst_halt",  16'(halted), 16'd0);
    chk("rst_cnt",   16'(fetch_cnt), 16'd0);
    rst = 1'b0;

    // straight line to halt
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sl_instr", instr, exp_sl[i]);
      chk("sl_ipc",   16'(instr_pc), 16'(i));
      chk("sl_valid", 16'(instr_valid), 16'd1);
      chk("sl_pc",    16'(pc), (i < 4) ? 16'(i + 1) : 16'd4);
      chk("sl_halt",  16'(halted), (i == 4) ? 16'd1 : 16'd0);
    end
    tick();
    chk("sl_valid_drop", 16'(instr_valid), 16'd0);
    chk("sl_cnt",        16'(fetch_cnt), 16'd5);
    chk("sl_pc_hold",    16'(pc), 16'd4);

    // halt is frozen against branches
    br_taken = 1'b1; br_target = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hf_pc",    16'(pc), 16'd4);
      chk("hf_instr", instr, 16'hF000);
      chk("hf_halt",  16'(halted), 16'd1);
      chk("hf_cnt",   16'(fetch_cnt), 16'd5);
    end
    br_taken = 1'b0;

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_pc",    16'(pc), 16'd0);
    chk("ar_instr", instr, 16'h0000);
    chk("ar_valid", 16'(instr_valid), 16'd0);
    chk("ar_halt",  16'(halted), 16'd0);
    chk("ar_cnt",   16'(fetch_cnt), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_refetch_instr", instr, 16'h0000);
    chk("ar_refetch_valid", 16'(instr_valid), 16'd1);
    chk("ar_refetch_pc",    16'(pc), 16'd1);

    // stall holds state
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("st_pre_instr", instr, 16'h1304);
    chk("st_pre_ipc",   16'(instr_pc), 16'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_instr", instr, 16'h1304);
      chk("st_ipc",   16'(instr_pc), 16'd2);
      chk("st_pc",    16'(pc), 16'd3);
      chk("st_cnt",   16'(fetch_cnt), 16'd3);
      chk("st_valid", 16'(instr_valid), 16'd1);
    end
    stall = 1'b0;
    tick();
    chk("st_resume_instr", instr, 16'h3C02);
    chk("st_resume_ipc",   16'(instr_pc), 16'd3);
    chk("st_resume_cnt",   16'(fetch_cnt), 16'd4);

    // stall and branch together: branch wins
    stall = 1'b1; br_taken = 1'b1; br_target = 4'd1;
    tick();
    chk("sb_valid", 16'(instr_valid), 16'd0);
    chk("sb_instr", instr, 16'h0000);
    chk("sb_pc",    16'(pc), 16'd1);
    chk("sb_cnt",   16'(fetch_cnt), 16'd4);
    stall = 1'b0; br_taken = 1'b0;
    tick();
    chk("sb_fetch_instr", instr, 16'h1400);
    chk("sb_fetch_ipc",   16'(instr_pc), 16'd1);

    // halt latched, then stalled: valid held until stall drops
    tick();
    tick();
    tick();
    chk("hs_instr", instr, 16'hF000);
    chk("hs_halt",  16'(halted), 16'd1);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hs_valid_hold", 16'(instr_valid), 16'd1);
    end
    stall = 1'b0;
    tick();
    chk("hs_valid_drop", 16'(instr_valid), 16'd0);

    // branch test: redirect to 7, then from 7 back to 4
    for (int i = 0; i < 16; i++) w[i] = 16'h0000;
    w[7] = 16'hB004; w[4] = 16'h1200; w[5] = 16'hF000;
    w[0] = 16'hF000;  // a halt under a redirect must not be seen
    rst = 1'b1;
    tick();
    br_taken = 1'b1; br_target = 4'd7;
    rst = 1'b0;
    tick();
    chk("br0_valid", 16'(instr_valid), 16'd0);
    chk("br0_halt",  16'(halted), 16'd0);
    chk("br0_pc",    16'(pc), 16'd7);
    br_taken = 1'b0;
    tick();
    chk("br_w7_instr", instr, 16'hB004);
    chk("br_w7_ipc",   16'(instr_pc), 16'd7);
    br_taken = 1'b1; br_target = 4'd4;
    tick();
    chk("br_bub_valid", 16'(instr_valid), 16'd0);
    chk("br_bub_instr", instr, 16'h0000);
    chk("br_bub_pc",    16'(pc), 16'd4);
    br_taken = 1'b0;
    tick();
    chk("br_t_instr", instr, 16'h1200);
    chk("br_t_ipc",   16'(instr_pc), 16'd4);
    chk("br_t_valid", 16'(instr_valid), 16'd1);
    tick();
    chk("br_h_instr", instr, 16'hF000);
    chk("br_h_halt",  16'(halted), 16'd1);
    chk("br_h_cnt",   16'(fetch_cnt), 16'd3);

    // wrap and saturation
    for (int i = 0; i < 16; i++) w[i] = 16'h0000;
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      tick();
      chk("wr_pc", 16'(pc), 16'(k % 16));
      if (k == 254) chk("wr_cnt254", 16'(fetch_cnt), 16'd254);
      if (k == 255) chk("wr_cnt255", 16'(fetch_cnt), 16'd255);
      if (k == 256) chk("wr_cnt_sat", 16'(fetch_cnt), 16'd255);
    end
    chk("wr_cnt_end", 16'(fetch_cnt), 16'd255);
    chk("wr_halt",    16'(halted), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
